// File: rtl/multi_cycle_controller.sv
// Control FSM for a multi-cycle MIPS-subset datapath: sequences FETCH/DECODE/execute
// states and decodes the datapath control lines from State, OpCode, Funct and Zero.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [4:0] ALUConf,
    output logic       Sign,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC      = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                           ALU_XOR = 5'd4, ALU_NOR = 5'd5, ALU_SL = 5'd6, ALU_SR = 5'd7,
                           ALU_COMP = 5'd8;

    state_t state;
    logic   is_rtype;
    logic   pc_write, mem_read, mem_write, ir_write, reg_write;

    assign State    = state;
    assign is_rtype = (OpCode == 6'h00);

    // R-type functions that produce a register result
    function automatic logic funct_known(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: funct_known = 1'b1;
            default:                                   funct_known = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (OpCode)
                        6'h23, 6'h2B:                      state <= MEM_ADDR;
                        6'h00:                             state <= (Funct == 6'h08 || Funct == 6'h09) ? JUMP : EXEC;
                        6'h08, 6'h09, 6'h0C, 6'h0A, 6'h0B,
                        6'h0F:                             state <= EXEC;
                        6'h04:                             state <= BRANCH;
                        6'h02, 6'h03:                      state <= JUMP;
                        default:                           state <= FETCH;
                    endcase
                end
                MEM_ADDR: state <= (OpCode == 6'h2B) ? MEM_WRITE : MEM_READ;
                MEM_READ: state <= MEM_WB;
                EXEC:     state <= ALU_WB;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        IorD      = 1'b0;
        ExtOp     = 1'b0;
        LuiOp     = 1'b0;
        MemtoReg  = 2'd0;
        RegDst    = 2'd0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        PCSource  = 2'd0;
        ALUConf   = ALU_ADD;
        Sign      = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'd1;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                ExtOp   = 1'b1;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ExtOp   = 1'b1;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            MEM_WB: begin
                reg_write = 1'b1;
                MemtoReg  = 2'd1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 2'd1;
                if (is_rtype) begin
                    case (Funct)
                        6'h22, 6'h23: ALUConf = ALU_SUB;
                        6'h24:        ALUConf = ALU_AND;
                        6'h25:        ALUConf = ALU_OR;
                        6'h26:        ALUConf = ALU_XOR;
                        6'h27:        ALUConf = ALU_NOR;
                        6'h2A:        begin ALUConf = ALU_COMP; Sign = 1'b1; end
                        6'h2B:        ALUConf = ALU_COMP;
                        6'h00:        begin ALUConf = ALU_SL; ALUSrcA = 2'd2; end
                        6'h02:        begin ALUConf = ALU_SR; ALUSrcA = 2'd2; end
                        6'h03:        begin ALUConf = ALU_SR; ALUSrcA = 2'd2; Sign = 1'b1; end
                        default:      ALUConf = ALU_ADD;
                    endcase
                end else begin
                    ALUSrcB = 2'd2;
                    case (OpCode)
                        6'h0C:   ALUConf = ALU_AND;
                        6'h0A:   begin ALUConf = ALU_COMP; Sign = 1'b1; ExtOp = 1'b1; end
                        6'h0B:   begin ALUConf = ALU_COMP; ExtOp = 1'b1; end
                        6'h0F:   LuiOp = 1'b1;
                        default: ExtOp = 1'b1;
                    endcase
                end
            end
            ALU_WB: begin
                RegDst    = is_rtype ? 2'd1 : 2'd0;
                reg_write = is_rtype ? funct_known(Funct) : 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 2'd1;
                ALUConf  = ALU_SUB;
                PCSource = 2'd1;
                pc_write = Zero;
            end
            JUMP: begin
                pc_write = 1'b1;
                if (is_rtype) begin
                    PCSource = 2'd3;
                    if (Funct == 6'h09) begin
                        reg_write = 1'b1;
                        RegDst    = 2'd1;
                        MemtoReg  = 2'd2;
                    end
                end else begin
                    PCSource = 2'd2;
                    if (OpCode == 6'h03) begin
                        reg_write = 1'b1;
                        RegDst    = 2'd2;
                        MemtoReg  = 2'd2;
                    end
                end
            end
            default: ;
        endcase
        // Reset suppresses every side effect immediately, independent of the clock
        PCWrite  = pc_write  & ~reset;
        MemRead  = mem_read  & ~reset;
        MemWrite = mem_write & ~reset;
        IRWrite  = ir_write  & ~reset;
        RegWrite = reg_write & ~reset;
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench for multi_cycle_controller: each instruction is expanded into its
// expected state/write-enable trace from the instruction class and checked cycle by cycle.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUConf;
    logic       Sign;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    multi_cycle_controller dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUConf(ALUConf), .Sign(Sign), .State(State)
    );

    always #5 clk = ~clk;

    typedef enum {C_NOP, C_LW, C_SW, C_ROK, C_RBAD, C_IMM, C_BEQ, C_J, C_JAL, C_JR, C_JALR} cls_t;
    typedef struct {
        logic [3:0] st;
        logic [4:0] en;   // {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}
    } step_t;

    step_t trace[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return C_JR;
                if (fn == 6'h09) return C_JALR;
                if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) return C_ROK;
                return C_RBAD;
            end
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h08, 6'h09, 6'h0C, 6'h0A, 6'h0B, 6'h0F: return C_IMM;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_NOP;
        endcase
    endfunction

    // {ALUConf, Sign, ALUSrcA, ALUSrcB, ExtOp, LuiOp} expected during the execute step
    function automatic logic [11:0] exp_exec(input logic [5:0] op, input logic [5:0] fn);
        logic [4:0] conf = 5'd0;
        logic       sgn = 1'b0, ext = 1'b0, lui = 1'b0;
        logic [1:0] sa = 2'd1, sb = 2'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h22, 6'h23: conf = 5'd1;
                6'h24: conf = 5'd2;
                6'h25: conf = 5'd3;
                6'h26: conf = 5'd4;
                6'h27: conf = 5'd5;
                6'h2A: begin conf = 5'd8; sgn = 1'b1; end
                6'h2B: conf = 5'd8;
                6'h00: begin conf = 5'd6; sa = 2'd2; end
                6'h02: begin conf = 5'd7; sa = 2'd2; end
                6'h03: begin conf = 5'd7; sa = 2'd2; sgn = 1'b1; end
                default: conf = 5'd0;
            endcase
        end else begin
            sb = 2'd2;
            case (op)
                6'h08, 6'h09: ext = 1'b1;
                6'h0C: conf = 5'd2;
                6'h0A: begin conf = 5'd8; sgn = 1'b1; ext = 1'b1; end
                6'h0B: begin conf = 5'd8; ext = 1'b1; end
                6'h0F: lui = 1'b1;
                default: ;
            endcase
        end
        return {conf, sgn, sa, sb, ext, lui};
    endfunction

    task automatic add_step(input logic [3:0] st, input logic [4:0] en);
        step_t s;
        s.st = st;
        s.en = en;
        trace.push_back(s);
    endtask

    task automatic build_trace(input cls_t c);
        trace.delete();
        add_step(4'd0, 5'b11010);
        add_step(4'd1, 5'b00000);
        case (c)
            C_LW:   begin add_step(4'd2, 5'b0); add_step(4'd3, 5'b01000); add_step(4'd4, 5'b00001); end
            C_SW:   begin add_step(4'd2, 5'b0); add_step(4'd5, 5'b00100); end
            C_ROK, C_IMM: begin add_step(4'd6, 5'b0); add_step(4'd7, 5'b00001); end
            C_RBAD: begin add_step(4'd6, 5'b0); add_step(4'd7, 5'b00000); end
            C_BEQ:  add_step(4'd8, 5'b00000);
            C_J, C_JR:     add_step(4'd9, 5'b10000);
            C_JAL, C_JALR: add_step(4'd9, 5'b10001);
            default: ;
        endcase
    endtask

    // Starts at a falling edge with State expected FETCH; ends at a falling edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
        cls_t       c = classify(op, fn);
        logic [4:0] exp_en;
        OpCode = op;
        Funct  = fn;
        build_trace(c);
        foreach (trace[k]) begin
            Zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
            #1;
            exp_en = trace[k].en;
            if (trace[k].st == 4'd8) exp_en[4] = Zero;
            chk("state", 32'(State), 32'(trace[k].st));
            chk("enables", 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite}), 32'(exp_en));
            case (trace[k].st)
                4'd0: chk("fetch_sel", 32'({IorD, ALUSrcA, ALUSrcB, ALUConf, PCSource}), 32'({1'b0, 2'd0, 2'd1, 5'd0, 2'd0}));
                4'd3: chk("memread_iord", 32'(IorD), 32'd1);
                4'd4: chk("memwb_sel", 32'({MemtoReg, RegDst}), 32'({2'd1, 2'd0}));
                4'd6: chk("exec_ctl", 32'({ALUConf, Sign, ALUSrcA, ALUSrcB, ExtOp, LuiOp}), 32'(exp_exec(op, fn)));
                4'd7: chk("aluwb_sel", 32'({MemtoReg, RegDst}), 32'({2'd0, (op == 6'h00) ? 2'd1 : 2'd0}));
                4'd8: chk("branch_ctl", 32'({ALUConf, PCSource, ALUSrcA, ALUSrcB}), 32'({5'd1, 2'd1, 2'd1, 2'd0}));
                4'd9: begin
                    case (c)
                        C_J:    chk("jump_ctl", 32'({PCSource, RegDst, MemtoReg}), 32'({2'd2, 2'd0, 2'd0}));
                        C_JAL:  chk("jump_ctl", 32'({PCSource, RegDst, MemtoReg}), 32'({2'd2, 2'd2, 2'd2}));
                        C_JR:   chk("jump_ctl", 32'({PCSource, RegDst, MemtoReg}), 32'({2'd3, 2'd0, 2'd0}));
                        default: chk("jump_ctl", 32'({PCSource, RegDst, MemtoReg}), 32'({2'd3, 2'd1, 2'd2}));
                    endcase
                end
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    logic [5:0] ops   [14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0C,
                               6'h0A, 6'h0B, 6'h0F, 6'h04, 6'h02, 6'h03};
    logic [5:0] functs[15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

    initial begin
        logic [5:0] op, fn;
        reset  = 1'b1;
        OpCode = 6'h00;
        Funct  = 6'h00;
        Zero   = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_enables", 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
        chk("rst_fetch_sel", 32'({IorD, ALUSrcA, ALUSrcB, ALUConf, PCSource}), 32'({1'b0, 2'd0, 2'd1, 5'd0, 2'd0}));
        @(posedge clk);
        #1 chk("rst_hold_state", 32'(State), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed: add, lw, beq taken/not, sra, sltu, jal, undefined, sw, lui, jr, jalr, bad funct, j
        run_instr(6'h00, 6'h20, -1);
        run_instr(6'h23, 6'h15, -1);
        run_instr(6'h04, 6'h00, 1);
        run_instr(6'h04, 6'h00, 0);
        run_instr(6'h00, 6'h03, -1);
        run_instr(6'h00, 6'h2B, -1);
        run_instr(6'h03, 6'h11, -1);
        run_instr(6'h3F, 6'h00, -1);
        run_instr(6'h2B, 6'h07, -1);
        run_instr(6'h0F, 6'h00, -1);
        run_instr(6'h00, 6'h08, -1);
        run_instr(6'h00, 6'h09, -1);
        run_instr(6'h00, 6'h3F, -1);
        run_instr(6'h02, 6'h00, -1);

        // Reset while in MEM_READ aborts the load
        OpCode = 6'h23;
        Funct  = 6'h00;
        repeat (3) @(negedge clk);
        chk("pre_abort_state", 32'(State), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_enables", 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1 chk("abort_hold_state", 32'(State), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'h23, 6'h00, -1);

        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 14)];
            run_instr(op, fn, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
